// File: rtl/pingpong_mux_ctrl.sv
// Scheduler for the registered 2:1 ping-pong mux: drains bank 0 and bank 1 in strict
// alternation, issuing select/address/read-enable and a release pulse after each drain.
module pingpong_mux_ctrl #(
  parameter int BLK_LEN    = 16,
  parameter int ADDR_W     = 4,
  parameter bit START_BANK = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        bank_full,
  input  logic              hold,
  output logic              sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic [1:0]        bank_release,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLK_LEN - 1);

  state_t            state_q, state_d;
  logic              next_bank_q, next_bank_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        release_q, release_d;
  logic              busy_q, busy_d;

  // Reads only stall on hold; hold has no influence outside a drain.
  assign rd_en        = (state_q == DRAIN) && !hold;
  assign rd_addr      = cnt_q;
  assign sel          = sel_q;
  assign out_valid    = out_valid_q;
  assign bank_release = release_q;
  assign busy         = busy_q;

  always_comb begin
    state_d     = state_q;
    next_bank_d = next_bank_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    release_d   = 2'b00;
    out_valid_d = rd_en;

    case (state_q)
      IDLE: begin
        if (bank_full[next_bank_q]) begin
          state_d = DRAIN;
          sel_d   = next_bank_q;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      DRAIN: begin
        if (rd_en) begin
          if (cnt_q == LAST_ADDR) begin
            state_d   = RELEASE;
            cnt_d     = '0;
            release_d = sel_q ? 2'b10 : 2'b01;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RELEASE: begin
        // sel is left alone so the final word still leaves through the same mux leg.
        next_bank_d = ~sel_q;
        state_d     = IDLE;
        busy_d      = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      next_bank_q <= START_BANK;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      release_q   <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_bank_q <= next_bank_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      release_q   <= release_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: doc/pingpong_mux_ctrl.md
Name: pingpong_mux_ctrl

Overview:
- Scheduler for the registered 2:1 sub-block mux in the ping-pong datapath.
- Drains two input banks strictly in alternation (bank 0, bank 1, bank 0, ...). For each drain it generates the mux select, the read address and the read enable.
- After each drain it pulses a release back to the producer of that bank.
- Generates an output-valid flag aligned with the mux's 1-cycle registered output.

Parameters:
- BLK_LEN, 16, words per bank drain (>=2).
- ADDR_W, 4, read-address width; must satisfy 2**ADDR_W >= BLK_LEN.
- START_BANK, 0, first bank expected after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- bank_full  in  2  level; bit b=1 means bank b holds a complete block ready to drain.
- hold  in  1  downstream back-pressure; while 1 no new read is issued.
- sel  out  1  mux select (0 = sub-block 0, 1 = sub-block 1); constant throughout a drain.
- rd_en  out  1  read issued this cycle to bank sel at rd_addr.
- rd_addr  out  ADDR_W  word address within the active bank.
- out_valid  out  1  mux output register holds a valid word (rd_en delayed 1 cycle).
- bank_release  out  2  one-cycle pulse on bit b when bank b has been fully read.
- busy  out  1  1 in DRAIN or RELEASE state.

Behaviour:
- Reset (async, any time, including mid-drain):
  - All outputs go to 0 immediately.
  - State goes to IDLE, next_bank is set to START_BANK, the word counter is cleared.
  - A partially drained bank is not released.
- Internal state:
  - next_bank (1 bit).
  - cnt (ADDR_W bits), word counter.
  - FSM states IDLE, DRAIN, RELEASE.
- IDLE:
  - rd_en=0, busy=0.
  - If bank_full[next_bank]=1: on the next edge sel<=next_bank, cnt<=0, go to DRAIN.
  - bank_full of the non-expected bank is ignored; strict alternation, no skipping.
- DRAIN:
  - busy=1. rd_en = ~hold (combinational from registered state and hold). rd_addr=cnt.
  - Each edge with rd_en=1: cnt increments.
  - Edge with rd_en=1 and cnt=BLK_LEN-1: go to RELEASE, cnt<=0.
  - hold=1: cnt and rd_addr frozen, rd_en=0. No limit on hold duration.
- RELEASE (exactly 1 cycle):
  - bank_release[sel]=1, rd_en=0.
  - next_bank <= ~sel. Go to IDLE.
  - sel keeps its value until the next DRAIN entry.
- Throughput and timing:
  - Minimum 2 idle cycles between the last read of one bank and the first read of the next (RELEASE + IDLE).
  - Block of BLK_LEN words with hold=0: rd_en high for exactly BLK_LEN consecutive cycles.
- out_valid:
  - Registered copy of rd_en; reset 0.
  - The mux registers the addressed word on the same edge, so out_valid and the mux output are aligned.
  - out_valid may be high in the RELEASE cycle for the final word.
- sel:
  - Changes only on the IDLE->DRAIN edge.
  - Never changes while rd_en=1 or while out_valid reflects the previous bank's last word.
- Producer contract:
  - Producer must drop bank_full[b] within 1 cycle of bank_release[b].
  - If bank_full[b] is still high when b is next expected, the controller drains it again (no error flag).
- Simultaneous bank_full[0]=bank_full[1]=1 in IDLE: next_bank wins, and the other bank is served next.
- hold asserted in IDLE or RELEASE: no effect on transitions.

Test Plan:
- Basic drain:
  - Stimulus: reset, START_BANK=0, BLK_LEN=16, bank_full=2'b01, hold=0.
  - Required: sel=0; rd_en high 16 cycles; rd_addr 0..15; out_valid high 16 cycles lagging by 1; bank_release=2'b01 for 1 cycle; next drain waits for bank 1.
- Alternation and ordering:
  - Stimulus: bank_full=2'b11 held; producer clears each bit on release and re-asserts 3 cycles later.
  - Required: drains in order 0,1,0,1 with sel toggling; 2-cycle gap between last read of one bank and first read of the next.
- Back-pressure:
  - Stimulus: hold=1 for cycles 5..9 of a drain.
  - Required: rd_addr frozen at 5; rd_en=0 for those 5 cycles; drain completes after 21 cycles total; no skipped or duplicated address.
- Wrong-bank ready:
  - Stimulus: after reset (expects 0), bank_full=2'b10 for 50 cycles.
  - Required: busy=0, rd_en=0 throughout; raising bit 0 starts a bank-0 drain.
- Reset mid-drain:
  - Stimulus: assert reset at rd_addr=7.
  - Required: all outputs 0 immediately; no bank_release; after reset, drain restarts on START_BANK from address 0.
- Boundary length:
  - Stimulus: BLK_LEN=2, ADDR_W=1.
  - Required: two reads (addresses 0,1), release, alternation correct; cnt wraps without overflow.
